// File: rtl/muldiv_unit_if.sv
// Issue/result bundle between the EX-stage pipeline (master) and muldiv_unit (slave).
// With MULDIV_FLUSH_EN defined the bundle also carries flush_in.
interface muldiv_unit_if #(
   parameter int XLEN = 32
);
   logic            start_in;
   logic [5:0]      aluop_in;
   logic [XLEN-1:0] A_in;
   logic [XLEN-1:0] B_in;
   logic [XLEN-1:0] result_out;
   logic [XLEN-1:0] hi_out;
   logic [XLEN-1:0] lo_out;
   logic            busy_out;
   logic            done_out;
   logic            div_by_zero_out;
`ifdef MULDIV_FLUSH_EN
   logic            flush_in;

   modport master (
      output start_in, aluop_in, A_in, B_in, flush_in,
      input  result_out, hi_out, lo_out, busy_out, done_out, div_by_zero_out
   );
   modport slave (
      input  start_in, aluop_in, A_in, B_in, flush_in,
      output result_out, hi_out, lo_out, busy_out, done_out, div_by_zero_out
   );
`else
   modport master (
      output start_in, aluop_in, A_in, B_in,
      input  result_out, hi_out, lo_out, busy_out, done_out, div_by_zero_out
   );
   modport slave (
      input  start_in, aluop_in, A_in, B_in,
      output result_out, hi_out, lo_out, busy_out, done_out, div_by_zero_out
   );
`endif
endinterface

// File: rtl/muldiv_unit.sv
// Multi-cycle MIPS32 MULT/MULTU/DIV/DIVU with HI/LO, one bit per cycle on magnitudes.
// Optional MULDIV_FLUSH_EN adds flush_in to abandon an operation in flight.
module muldiv_unit #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 6
) (
   input logic          clk,
   input logic          rst_n,
   muldiv_unit_if.slave bus
);
   localparam logic [5:0] OP_MULT  = 6'b011000;
   localparam logic [5:0] OP_MULTU = 6'b011001;
   localparam logic [5:0] OP_DIV   = 6'b011010;
   localparam logic [5:0] OP_DIVU  = 6'b011011;
   localparam logic [5:0] OP_MFHI  = 6'b010000;
   localparam logic [5:0] OP_MTHI  = 6'b010001;
   localparam logic [5:0] OP_MFLO  = 6'b010010;
   localparam logic [5:0] OP_MTLO  = 6'b010011;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN - 1);

   typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

   state_t            state_reg;
   logic [XLEN-1:0]   hi_reg, lo_reg, opnd_reg;
   logic [2*XLEN-1:0] acc_reg;
   logic [CNT_W-1:0]  cnt_reg;
   logic              neg_res_reg, neg_rem_reg, is_div_reg, dbz_pend_reg;
   logic              busy_reg, done_reg, dbz_reg;

   // Operand magnitudes; -MIN_INT wraps to itself, which is 2^31 read as unsigned.
   logic            signed_op, a_neg, b_neg;
   logic [XLEN-1:0] a_mag, b_mag;
   always_comb begin
      signed_op = (bus.aluop_in == OP_MULT) || (bus.aluop_in == OP_DIV);
      a_neg     = signed_op & bus.A_in[XLEN-1];
      b_neg     = signed_op & bus.B_in[XLEN-1];
      a_mag     = a_neg ? -bus.A_in : bus.A_in;
      b_mag     = b_neg ? -bus.B_in : bus.B_in;
   end

   // Multiply: acc = {partial product, remaining multiplier bits}, shifted right each step.
   logic [XLEN:0]     mul_sum;
   logic [2*XLEN-1:0] mul_next;
   always_comb begin
      mul_sum  = {1'b0, acc_reg[2*XLEN-1:XLEN]} + (acc_reg[0] ? {1'b0, opnd_reg} : '0);
      mul_next = {mul_sum, acc_reg[XLEN-1:1]};
   end

   // Divide: acc = {partial remainder, dividend/quotient bits}, shifted left each step.
   logic [2*XLEN:0]   div_shift;
   logic              div_ge;
   logic [XLEN-1:0]   div_rem;
   logic [2*XLEN-1:0] div_next;
   always_comb begin
      div_shift = {acc_reg, 1'b0};
      div_ge    = div_shift[2*XLEN:XLEN] >= {1'b0, opnd_reg};
      div_rem   = div_shift[2*XLEN-1:XLEN] - opnd_reg;
      div_next  = div_ge ? {div_rem, div_shift[XLEN-1:1], 1'b1} : div_shift[2*XLEN-1:0];
   end

   logic [2*XLEN-1:0] prod_fix;
   logic [XLEN-1:0]   quot_fix, rem_fix;
   always_comb begin
      prod_fix = neg_res_reg ? -acc_reg : acc_reg;
      quot_fix = neg_res_reg ? -acc_reg[XLEN-1:0] : acc_reg[XLEN-1:0];
      rem_fix  = neg_rem_reg ? -acc_reg[2*XLEN-1:XLEN] : acc_reg[2*XLEN-1:XLEN];
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg    <= S_IDLE;
         hi_reg       <= '0;
         lo_reg       <= '0;
         opnd_reg     <= '0;
         acc_reg      <= '0;
         cnt_reg      <= '0;
         neg_res_reg  <= 1'b0;
         neg_rem_reg  <= 1'b0;
         is_div_reg   <= 1'b0;
         dbz_pend_reg <= 1'b0;
         busy_reg     <= 1'b0;
         done_reg     <= 1'b0;
         dbz_reg      <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         dbz_reg  <= 1'b0;
         case (state_reg)
            S_IDLE: begin
               if (bus.start_in) begin
                  case (bus.aluop_in)
                     OP_MTHI: hi_reg <= bus.A_in;
                     OP_MTLO: lo_reg <= bus.A_in;
                     OP_MULT, OP_MULTU: begin
                        acc_reg      <= {{XLEN{1'b0}}, b_mag};
                        opnd_reg     <= a_mag;
                        neg_res_reg  <= a_neg ^ b_neg;
                        neg_rem_reg  <= 1'b0;
                        is_div_reg   <= 1'b0;
                        dbz_pend_reg <= 1'b0;
                        cnt_reg      <= '0;
                        busy_reg     <= 1'b1;
                        state_reg    <= S_MUL;
                     end
                     OP_DIV, OP_DIVU: begin
                        acc_reg      <= {{XLEN{1'b0}}, a_mag};
                        opnd_reg     <= b_mag;
                        neg_res_reg  <= a_neg ^ b_neg;
                        neg_rem_reg  <= a_neg;
                        is_div_reg   <= 1'b1;
                        cnt_reg      <= '0;
                        busy_reg     <= 1'b1;
                        dbz_pend_reg <= (bus.B_in == '0);
                        state_reg    <= (bus.B_in == '0) ? S_DONE : S_DIV;
                     end
                     default: ;
                  endcase
               end
            end
            S_MUL: begin
               acc_reg <= mul_next;
               cnt_reg <= cnt_reg + 1'b1;
               if (cnt_reg == LAST_CNT) state_reg <= S_FIX;
            end
            S_DIV: begin
               acc_reg <= div_next;
               cnt_reg <= cnt_reg + 1'b1;
               if (cnt_reg == LAST_CNT) state_reg <= S_FIX;
            end
            S_FIX: begin
               if (is_div_reg) begin
                  hi_reg <= rem_fix;
                  lo_reg <= quot_fix;
               end else begin
                  hi_reg <= prod_fix[2*XLEN-1:XLEN];
                  lo_reg <= prod_fix[XLEN-1:0];
               end
               state_reg <= S_DONE;
            end
            S_DONE: begin
               done_reg  <= 1'b1;
               dbz_reg   <= dbz_pend_reg;
               busy_reg  <= 1'b0;
               state_reg <= S_IDLE;
            end
            default: state_reg <= S_IDLE;
         endcase
`ifdef MULDIV_FLUSH_EN
         // Overrides the case above, including the HI/LO write in FIX.
         if (bus.flush_in && state_reg != S_IDLE) begin
            state_reg <= S_IDLE;
            hi_reg    <= hi_reg;
            lo_reg    <= lo_reg;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            dbz_reg   <= 1'b0;
         end
`endif
      end
   end

   always_comb begin
      case (bus.aluop_in)
         OP_MFHI: bus.result_out = hi_reg;
         OP_MFLO: bus.result_out = lo_reg;
         default: bus.result_out = '0;
      endcase
   end

   assign bus.hi_out          = hi_reg;
   assign bus.lo_out          = lo_reg;
   assign bus.busy_out        = busy_reg;
   assign bus.done_out        = done_reg;
   assign bus.div_by_zero_out = dbz_reg;
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Multi-cycle MIPS32 multiply/divide responder with HI/LO registers; sits beside the ALU in EX.
- Accepts the same 6-bit funct-style aluop the ALU decodes: MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI, MTLO.
- The pipeline issues ops with a start handshake.
- The unit reports busy/done so the pipeline can stall MFHI/MFLO and any new mul/div until the result is written.

Parameters:
- XLEN, 32, operand/HI/LO width.
- CNT_W, 6, iteration counter width; must hold XLEN.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- start_in  input  1  issue strobe, sampled at the rising edge.
- aluop_in  input  6  op: 011000 MULT, 011001 MULTU, 011010 DIV, 011011 DIVU, 010000 MFHI, 010001 MTHI, 010010 MFLO, 010011 MTLO.
- A_in  input  XLEN  rs operand / dividend / MTHI-MTLO data.
- B_in  input  XLEN  rt operand / divisor.
- result_out  output  XLEN  HI when aluop_in=MFHI, LO when MFLO, else 0. Combinational from the HI/LO registers.
- hi_out  output  XLEN  HI register.
- lo_out  output  XLEN  LO register.
- busy_out  output  1  operation in progress.
- done_out  output  1  one-cycle pulse: HI/LO just written by a mul/div.
- div_by_zero_out  output  1  valid with done_out; 1 = divisor was zero.

Behaviour:
- Reset (rst_n=0 at an edge):
  - HI=LO=0, state IDLE, counter 0.
  - busy_out=0, done_out=0, div_by_zero_out=0.
  - Reset has priority over every other event, including mid-operation: the op is abandoned and no done is produced.
- States: IDLE, MUL, DIV, FIX, DONE.
- IDLE, start_in=1:
  - MTHI/MTLO: HI or LO <= A_in at that edge. No busy, no done.
  - MFHI/MFLO or an unlisted op: no state change.
  - MULT/MULTU/DIV/DIVU: latch operands, go to MUL or DIV.
  - Signed ops store magnitudes plus the result sign(s).
  - Counter <= 0; busy_out=1 from the next cycle.
- Divide by zero (DIV/DIVU with B_in=0):
  - Go straight to DONE. HI/LO are not modified.
  - div_by_zero_out=1 together with the done_out pulse.
- MUL: 32 shift-add iterations on the 64-bit product register, one bit per cycle. Then FIX.
- DIV: 32 restoring shift-subtract iterations, one quotient bit per cycle. Then FIX.
- FIX (one cycle):
  - Apply two's-complement sign correction.
  - Product sign = signA XOR signB.
  - Quotient sign = signA XOR signB, truncated toward zero.
  - Remainder takes the dividend's sign.
  - Write HI/LO: product high/low for multiply; remainder/quotient for divide.
  - Go to DONE.
- DONE: done_out=1 for exactly one cycle, busy_out=0, return to IDLE.
- Latency:
  - Start edge E0; iterations on E1..E32; FIX on E33.
  - done_out is high during the cycle after E34; busy_out is high from after E0 through E34.
  - Divide by zero: done_out is high during the cycle after E1.
- start_in while state is not IDLE: ignored entirely (no op latched, HI/LO untouched). The pipeline must stall on busy_out.
- start_in in the DONE cycle: ignored. A new op is accepted only in IDLE.
- MIN_INT/-1 signed divide: LO=0x80000000, HI=0, div_by_zero_out=0. No trap.
- MULTU/DIVU treat operands as unsigned. 0x80000000 magnitude is handled as the unsigned value 2^31.
- result_out reflects HI/LO register contents. MFHI issued the cycle after an MTHI edge returns the new value.

Optional Feature:
- Macro: MULDIV_FLUSH_EN.
- Defined:
  - Adds input port flush_in (1 bit).
  - flush_in=1 at an edge in MUL, DIV, FIX or DONE forces IDLE.
  - HI/LO keep their pre-operation values, no done_out pulse, busy_out=0 next cycle.
  - flush_in in IDLE has no effect; MTHI/MTLO on the same edge still write.
  - rst_n still has priority over flush_in.
- Undefined: port absent; an operation always runs to completion.

Test Plan:
- MULTU A=0xFFFFFFFF B=0xFFFFFFFF, start at E0 -> busy_out=1 after E0, done_out high one cycle after E34, HI=0xFFFFFFFE, LO=0x00000001.
- MULT A=0xFFFFFFFD (-3) B=0x00000007 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB (-21). DIV A=0xFFFFFFF9 (-7) B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU same operands -> LO=0x7FFFFFFC, HI=0x00000001.
- HI=LO=0x11111111 preset via MTHI/MTLO; DIV A=5 B=0 -> done_out pulse after E1 with div_by_zero_out=1, HI/LO remain 0x11111111. DIV A=0x80000000 B=0xFFFFFFFF -> LO=0x80000000, HI=0.
- MTHI A=0x12345678, then aluop_in=MFHI next cycle -> result_out=0x12345678, busy_out stays 0. MFLO -> LO value.
- MULT in progress, start_in=1 with DIVU at iteration 5 -> ignored, first result correct, only one done_out pulse.
- rst_n=0 at iteration 10 of a DIV -> next cycle HI=LO=0, busy_out=0, no done_out. With MULDIV_FLUSH_EN, flush_in at iteration 10 -> HI/LO unchanged, busy_out=0, no done_out.
